// File: rtl/regpair_writer_pkg.sv
// Shared constants for the register-pair writer: pair/register selects and the hold record.
package regpair_writer_pkg;

   typedef enum logic [1:0] {
      pair_BC = 2'd0,
      pair_DE = 2'd1,
      pair_HL = 2'd2,
      pair_AF = 2'd3
   } pair_sel_t;

   typedef enum logic [2:0] {
      reg_B = 3'd0,
      reg_C = 3'd1,
      reg_D = 3'd2,
      reg_E = 3'd3,
      reg_H = 3'd4,
      reg_L = 3'd5,
      reg_F = 3'd6,
      reg_A = 3'd7
   } reg_sel_t;

   typedef struct packed {
      pair_sel_t   pair;
      logic [15:0] data;
   } hold_t;

   // Only named pairs start a transfer; anything else is swallowed on acceptance.
   function automatic logic pair_known(input pair_sel_t p);
      case (p)
         pair_BC, pair_DE, pair_HL, pair_AF: pair_known = 1'b1;
         default:                            pair_known = 1'b0;
      endcase
   endfunction

   function automatic reg_sel_t hi_reg(input pair_sel_t p);
      case (p)
         pair_BC: hi_reg = reg_B;
         pair_DE: hi_reg = reg_D;
         pair_HL: hi_reg = reg_H;
         default: hi_reg = reg_A;
      endcase
   endfunction

   function automatic reg_sel_t lo_reg(input pair_sel_t p);
      case (p)
         pair_BC: lo_reg = reg_C;
         pair_DE: lo_reg = reg_E;
         pair_HL: lo_reg = reg_L;
         default: lo_reg = reg_F;
      endcase
   endfunction

endpackage

// File: rtl/regpair_writer.sv
// Splits a 16-bit pair write into high-then-low byte strobes to an 8-bit register file.
// Optional REGPAIR_FLAGS_EN routes the AF low byte's upper nibble to a flags strobe.
module regpair_writer
   import regpair_writer_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  pair_sel_t   wr_pair,
   input  logic [15:0] wr_data,
   output logic [7:0]  rf_data,
   output logic        rf_load_en,
   output reg_sel_t    rf_sel,
   output logic [3:0]  flags_out,
   output logic        flags_we,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WR_HI = 2'd1,
      WR_LO = 2'd2
   } state_t;

   state_t state_q, state_d;
   hold_t  hold_q, hold_d;
   logic   accept;

   assign wr_ready = (state_q != WR_HI);
   assign busy     = (state_q != IDLE);
   assign accept   = wr_valid && wr_ready;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      if (accept) begin
         hold_d.pair = wr_pair;
         hold_d.data = wr_data;
      end
      case (state_q)
         IDLE:    state_d = (accept && pair_known(wr_pair)) ? WR_HI : IDLE;
         WR_HI:   state_d = WR_LO;
         WR_LO:   state_d = (accept && pair_known(wr_pair)) ? WR_HI : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   // Outputs come only from registered state, so a request taken in WR_LO
   // overwrites hold_q at the edge without disturbing the byte on the bus now.
   logic [3:0] flags_d;
   logic       flags_we_d;

   always_comb begin
      rf_load_en = 1'b0;
      rf_data    = 8'h00;
      rf_sel     = reg_A;
      flags_d    = 4'h0;
      flags_we_d = 1'b0;
      case (state_q)
         WR_HI: begin
            rf_load_en = 1'b1;
            rf_data    = hold_q.data[15:8];
            rf_sel     = hi_reg(hold_q.pair);
         end
         WR_LO: begin
            if (hold_q.pair != pair_AF) begin
               rf_load_en = 1'b1;
               rf_data    = hold_q.data[7:0];
               rf_sel     = lo_reg(hold_q.pair);
            end else begin
               flags_d    = hold_q.data[7:4];
               flags_we_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

`ifdef REGPAIR_FLAGS_EN
   assign flags_out = flags_d;
   assign flags_we  = flags_we_d;
`else
   // AF writes only A; the low byte has nowhere to go.
   logic unused_flags;
   assign unused_flags = ^{flags_d, flags_we_d};
   assign flags_out    = 4'h0;
   assign flags_we     = 1'b0;
`endif

endmodule

// File: doc/regpair_writer.md
REGPAIR_WRITER -- requirements
Module: regpair_writer

Interface
REQ-001 The block SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 The block SHALL have ports: rst  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-003 The block SHALL have ports: wr_valid  input  1  request valid; wr_ready  output  1  request accepted when wr_valid and wr_ready are both 1 at a clk edge.
REQ-004 The block SHALL have ports: wr_pair  input  pair_sel_t  target pair (pair_BC, pair_DE, pair_HL, pair_AF); wr_data  input  16  value, high byte to first register.
REQ-005 The block SHALL have ports: rf_data  output  8  byte to register file write port; rf_load_en  output  1  write strobe; rf_sel  output  reg_sel_t  target register.
REQ-006 The block SHALL have ports: flags_out  output  4  flag value for the AF low byte; flags_we  output  1  flags update strobe; busy  output  1  transfer in progress.

Function
REQ-007 The block SHALL use FSM states IDLE, WR_HI and WR_LO, held in a state register.
REQ-008 wr_ready SHALL be 1 in IDLE and WR_LO and 0 in WR_HI.
REQ-009 On acceptance, the block SHALL capture wr_pair and wr_data into a hold register and enter WR_HI at the same edge.
REQ-010 In WR_HI, the block SHALL drive rf_load_en=1, rf_data=hold[15:8] and rf_sel set to the high register of the pair (B, D, H, A), then go to WR_LO.
REQ-011 In WR_LO for BC/DE/HL, the block SHALL drive rf_load_en=1, rf_data=hold[7:0] and rf_sel set to the low register (C, E, L).
REQ-012 In WR_LO, the next state SHALL be WR_HI when a new request is accepted that cycle, otherwise IDLE.
REQ-013 Outputs SHALL be combinational from the state and hold registers; a request accepted during WR_LO SHALL NOT corrupt the low byte being driven in that cycle.
REQ-014 Latency SHALL be: accept at edge N, high byte loaded at edge N+1, low byte loaded at edge N+2; sustained throughput SHALL be one pair per 2 cycles.
REQ-015 In IDLE, the block SHALL drive rf_load_en=0, flags_we=0, rf_data=0 and rf_sel=reg_A.
REQ-016 busy SHALL be 1 exactly when the state is not IDLE.
REQ-017 wr_valid deasserted while wr_ready=0 SHALL have no effect, and no request SHALL be lost or duplicated.
REQ-018 Every pair_sel_t encoding not named in REQ-004 SHALL be accepted and discarded: no strobes, state remains IDLE.

Reset
REQ-019 While rst=0, the block SHALL force the state to IDLE and the hold register to 0, with outputs: wr_ready=1, busy=0, rf_load_en=0, flags_we=0, rf_data=0, rf_sel=reg_A, flags_out=0.
REQ-020 Reset asserted mid-transfer SHALL abort it immediately, with no further strobes for that request after reset release.

Configuration
REQ-021 With REGPAIR_FLAGS_EN defined, WR_LO for pair_AF SHALL drive flags_we=1, flags_out=hold[7:4] and rf_load_en=0.
REQ-022 Without REGPAIR_FLAGS_EN, pair_AF SHALL write A only; WR_LO for AF SHALL assert no strobe; flags_out SHALL be tied 0 and flags_we SHALL be tied 0.

Structure
REQ-023 pair_sel_t (2-bit enum) SHALL live in the shared constants package alongside reg_sel_t, and the FSM state enum SHALL be local to the module.
REQ-024 The block SHALL be a single module with no sub-module.

Verification
REQ-025 The bench SHALL cover: wr_pair=BC, wr_data=16'h12_34 accepted at edge 0 -> edge 1 load B=8'h12, edge 2 load C=8'h34, then IDLE.
REQ-026 The bench SHALL cover: HL=16'hABCD then DE=16'h0102 with wr_valid held -> strobes H,L,D,E on four consecutive edges, wr_ready low only in WR_HI cycles.
REQ-027 The bench SHALL cover: with REGPAIR_FLAGS_EN, AF=16'h77_B0 -> A=8'h77 loaded, then flags_we=1 with flags_out=4'hB, rf_load_en=0.
REQ-028 The bench SHALL cover: without REGPAIR_FLAGS_EN, AF=16'h77_B0 -> A=8'h77 loaded, then no strobe, flags_we=0 throughout.
REQ-029 The bench SHALL cover: rst driven 0 during WR_HI of DE=16'h5566 -> outputs reach reset values without a clock edge, and no D/E strobe occurs after release.
REQ-030 The bench SHALL cover: wr_valid pulsed during WR_HI with DE=16'h9999 -> not accepted; only the original pair is written.
